segment_capture_avalon: RTL and testbench

- Receive-side counterpart of the multiplexed 4-digit seven-segment driver.
- Monitors the driver's `digits`/`segments` scan outputs and decodes each digit pattern back to BCD.
- Converts a complete 4-digit frame to binary and exposes the result to an Avalon-MM master as a readable slave.
- Used for loopback self-test of display paths and for readback of captured display values.

---
 rtl/segment_pkg.sv | 48 ++++
 rtl/segment_digit_filter.sv | 73 +++++++
 rtl/segment_capture_avalon.sv | 161 ++++++++++++++++
 tb/tb_segment_capture_avalon.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segment_pkg.sv
// Shared seven-segment definitions for the display capture path: pattern constants,
// register addresses, capture FSM states and the pattern-to-BCD decoder.
package segment_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ADDR_VALUE  = 1'b0,
        ADDR_STATUS = 1'b1
    } addr_e;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        CONVERT = 2'd1,
        PUBLISH = 2'd2
    } state_e;

    // Returns {valid, nibble}; a blank digit reads as zero (leading-zero blanking).
    function automatic logic [4:0] seg_to_bcd(input logic [6:0] seg);
        case (seg)
            SEG_0:     return {1'b1, 4'd0};
            SEG_1:     return {1'b1, 4'd1};
            SEG_2:     return {1'b1, 4'd2};
            SEG_3:     return {1'b1, 4'd3};
            SEG_4:     return {1'b1, 4'd4};
            SEG_5:     return {1'b1, 4'd5};
            SEG_6:     return {1'b1, 4'd6};
            SEG_7:     return {1'b1, 4'd7};
            SEG_8:     return {1'b1, 4'd8};
            SEG_9:     return {1'b1, 4'd9};
            SEG_BLANK: return {1'b1, 4'd0};
            default:   return {1'b0, 4'd0};
        endcase
    endfunction

endpackage

// File: rtl/segment_digit_filter.sv
// Samples the scan bus, counts how long {digits, segments} stays unchanged and emits
// a single accept pulse (with slot index and pattern) once a one-hot digit is stable.
module segment_digit_filter
    import segment_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_DIGITS-1:0] i_digits,
    input  logic [6:0]            i_segments,
    output logic                  o_accept,
    output logic [1:0]            o_slot,
    output logic [6:0]            o_seg
);

    localparam int CW = $clog2(STABLE_CYCLES + 2);
    localparam logic [CW-1:0] C_STABLE = CW'(STABLE_CYCLES);
    // Saturating one past the threshold keeps the accept from repeating on a long hold.
    localparam logic [CW-1:0] C_SAT    = CW'(STABLE_CYCLES + 1);

    logic [10:0]   r_samp;
    logic [10:0]   r_prev;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_onehot;
    logic [1:0]    w_slot;

    // Stability counter: restart at one on any change, otherwise count up to saturation.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_samp != r_prev) begin
            w_cnt_nxt = CW'(1);
        end else if (r_cnt != C_SAT) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // One-hot digit select to slot index; anything else is never accepted.
    always_comb begin
        w_onehot = 1'b0;
        w_slot   = 2'd0;
        case (r_samp[10:7])
            4'b0001: begin w_onehot = 1'b1; w_slot = 2'd0; end
            4'b0010: begin w_onehot = 1'b1; w_slot = 2'd1; end
            4'b0100: begin w_onehot = 1'b1; w_slot = 2'd2; end
            4'b1000: begin w_onehot = 1'b1; w_slot = 2'd3; end
            default: begin w_onehot = 1'b0; w_slot = 2'd0; end
        endcase
    end

    // Input sampling, counter state and registered accept outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_samp   <= 11'd0;
            r_prev   <= 11'd0;
            r_cnt    <= '0;
            o_accept <= 1'b0;
            o_slot   <= 2'd0;
            o_seg    <= 7'd0;
        end else begin
            r_samp   <= {i_digits, i_segments};
            r_prev   <= r_samp;
            r_cnt    <= w_cnt_nxt;
            o_accept <= (w_cnt_nxt == C_STABLE) && w_onehot;
            o_slot   <= w_slot;
            o_seg    <= r_samp[6:0];
        end
    end

endmodule

// File: rtl/segment_capture_avalon.sv
// Captures a scanned 4-digit seven-segment frame, converts it to binary and serves it
// over an Avalon-MM slave. Define SEG_CAPTURE_IRQ_EN to add the irq output (new | error).
module segment_capture_avalon
    import segment_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_DIGITS-1:0] digits,
    input  logic [6:0]            segments,
    input  logic                  read,
    input  logic                  address,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid
`ifdef SEG_CAPTURE_IRQ_EN
    ,
    output logic                  irq
`endif
);

    state_e                  r_state;
    logic [NUM_DIGITS-1:0]   r_mask;
    logic [15:0]             r_slots;
    logic [13:0]             r_acc;
    logic [13:0]             r_value;
    logic [1:0]              r_idx;
    logic                    r_new;
    logic                    r_error;
    logic [DATA_WIDTH-1:0]   r_readdata;
    logic                    r_readdatavalid;

    logic                    w_accept;
    logic [1:0]              w_slot;
    logic [6:0]              w_seg;
    logic [4:0]              w_bcd;
    logic [3:0]              w_digit;
    logic [13:0]             w_acc_nxt;
    logic                    w_val_rd;
    logic                    w_st_rd;
    logic                    w_new_set;
    logic                    w_err_set;

    segment_digit_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .reset      (reset),
        .i_digits   (digits),
        .i_segments (segments),
        .o_accept   (w_accept),
        .o_slot     (w_slot),
        .o_seg      (w_seg)
    );

    assign w_bcd     = seg_to_bcd(w_seg);
    assign w_digit   = r_slots[{r_idx, 2'b00} +: 4];
    // acc*10 as acc*8 + acc*2; 9999 is the largest result so 14 bits never overflow.
    assign w_acc_nxt = {r_acc[10:0], 3'b000} + {r_acc[12:0], 1'b0} + {10'd0, w_digit};
    assign w_val_rd  = read && (address == ADDR_VALUE);
    assign w_st_rd   = read && (address == ADDR_STATUS);
    assign w_new_set = (r_state == PUBLISH);
    assign w_err_set = (r_state == CAPTURE) && (r_mask != 4'b1111) && w_accept && !w_bcd[4];

    // Capture / convert / publish sequencing with slot storage and the binary accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CAPTURE;
            r_mask  <= 4'b0000;
            r_slots <= 16'd0;
            r_acc   <= 14'd0;
            r_idx   <= 2'd0;
            r_value <= 14'd0;
        end else begin
            case (r_state)
                CAPTURE: begin
                    if (r_mask == 4'b1111) begin
                        r_state <= CONVERT;
                        r_acc   <= 14'd0;
                        r_idx   <= 2'd3;
                    end else if (w_accept) begin
                        if (w_bcd[4]) begin
                            r_slots[{w_slot, 2'b00} +: 4] <= w_bcd[3:0];
                            r_mask[w_slot]                <= 1'b1;
                        end else begin
                            r_mask <= 4'b0000;
                        end
                    end else begin
                        r_mask <= r_mask;
                    end
                end
                CONVERT: begin
                    r_acc <= w_acc_nxt;
                    r_idx <= r_idx - 2'd1;
                    if (r_idx == 2'd0) begin
                        r_state <= PUBLISH;
                    end else begin
                        r_state <= CONVERT;
                    end
                end
                PUBLISH: begin
                    r_value <= r_acc;
                    r_mask  <= 4'b0000;
                    r_state <= CAPTURE;
                end
                default: begin
                    r_state <= CAPTURE;
                    r_mask  <= 4'b0000;
                end
            endcase
        end
    end

    // Sticky status flags; a set in the same cycle as a clearing read wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_new   <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_new   <= w_new_set | (r_new & ~w_val_rd);
            r_error <= w_err_set | (r_error & ~w_st_rd);
        end
    end

    // Registered Avalon read port, one-cycle fixed latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= read;
            if (w_val_rd) begin
                r_readdata <= DATA_WIDTH'(r_value);
            end else if (w_st_rd) begin
                r_readdata <= DATA_WIDTH'({r_error, r_new});
            end else begin
                r_readdata <= r_readdata;
            end
        end
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;

`ifdef SEG_CAPTURE_IRQ_EN
    logic r_irq;

    // Interrupt follows the sticky flags one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_new | r_error;
        end
    end

    assign irq = r_irq;
`endif

endmodule

// File: tb/tb_segment_capture_avalon.sv
// Self-checking bench for segment_capture_avalon: scans decimal values onto the
// digits/segments bus and compares Avalon reads against the numbers that were scanned.
module tb_segment_capture_avalon;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  digits = 4'd0;
    logic [6:0]  segments = 7'd0;
    logic        read = 1'b0;
    logic        address = 1'b0;
    logic [15:0] readdata;
    logic        readdatavalid;
`ifdef SEG_CAPTURE_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int pw [5] = '{1, 10, 100, 1000, 10000};

    segment_capture_avalon #(
        .STABLE_CYCLES(4),
        .DATA_WIDTH(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .digits        (digits),
        .segments      (segments),
        .read          (read),
        .address       (address),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
`ifdef SEG_CAPTURE_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
        digits = d;
        segments = s;
        cyc(n);
    endtask

    task automatic idle(input int n);
        hold(4'd0, 7'd0, n);
    endtask

    // Scan a decimal value MSD first; the top nlead digits are shown blank.
    task automatic scan_value(input int v, input int nlead, input int h, input bit skip_last);
        logic [6:0] p;
        for (int k = 3; k >= 0; k--) begin
            if (!(skip_last && k == 0)) begin
                p = (k >= 4 - nlead) ? 7'h00 : seg_tab[(v / pw[k]) % 10];
                hold(4'(1 << k), p, h);
            end
        end
    endtask

    task automatic do_read(input logic a, output logic [15:0] d, output logic v);
        read = 1'b1;
        address = a;
        cyc(1);
        read = 1'b0;
        d = readdata;
        v = readdatavalid;
    endtask

    // Scans a random value from an idle bus and finds the edge (counted from the start of
    // the units-digit hold) at which it is published, by polling STATUS every cycle.
    task automatic calibrate(output int p, output int v);
        logic [15:0] rd;
        logic        rv;
        v = $urandom_range(1000, 9999);
        idle(10);
        scan_value(v, 0, 10, 1'b1);
        p = -1;
        for (int c = 0; c < 40; c++) begin
            if (c < 10) begin
                digits = 4'b0001;
                segments = seg_tab[v % 10];
            end else begin
                digits = 4'd0;
                segments = 7'd0;
            end
            read = 1'b1;
            address = 1'b1;
            cyc(1);
            if (p < 0 && readdata[0] === 1'b1) p = c - 1;
        end
        read = 1'b0;
        checks++;
        if (p < 5) begin
            errors++;
            $display("FAIL calib_publish got_edge=%0d want>=5", p);
        end
        do_read(1'b0, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'(v)}) begin
            errors++;
            $display("FAIL calib_value got=%b/%h want=1/%h", rv, rd, 16'(v));
        end
    endtask

    task automatic test_reset;
        logic [15:0] rd;
        logic        rv;
        cyc(3);
        checks++;
        if ({readdatavalid, readdata} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b/%h want=0/0000", readdatavalid, readdata);
        end
        reset = 1'b1;
        cyc(2);
        do_read(1'b1, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL reset_status got=%b/%h want=1/0000", rv, rd);
        end
        do_read(1'b0, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL reset_value got=%b/%h want=1/0000", rv, rd);
        end
    endtask

    task automatic test_scan_1234;
        logic [15:0] rd;
        logic        rv;
        idle(5);
        hold(4'b1000, 7'h06, 10);
        hold(4'b0100, 7'h5B, 10);
        hold(4'b0010, 7'h4F, 10);
        hold(4'b0001, 7'h66, 10);
        idle(12);
        do_read(1'b1, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'h0001}) begin
            errors++;
            $display("FAIL s1234_status got=%b/%h want=1/0001", rv, rd);
        end
        do_read(1'b0, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'h04D2}) begin
            errors++;
            $display("FAIL s1234_value got=%b/%h want=1/04d2", rv, rd);
        end
        cyc(1);
        checks++;
        if (readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL rdvalid_pulse got=%b want=0", readdatavalid);
        end
        do_read(1'b1, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL s1234_status_clr got=%b/%h want=1/0000", rv, rd);
        end
    endtask

    task automatic test_blank;
        logic [15:0] rd;
        logic        rv;
        idle(5);
        scan_value(3999, 0, 10, 1'b0);
        idle(12);
        do_read(1'b0, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'h0F9F}) begin
            errors++;
            $display("FAIL s3999_value got=%b/%h want=1/0f9f", rv, rd);
        end
        scan_value(42, 2, 10, 1'b0);
        idle(12);
        do_read(1'b0, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'h002A}) begin
            errors++;
            $display("FAIL s0042_blank got=%b/%h want=1/002a", rv, rd);
        end
    endtask

    task automatic test_glitch;
        logic [15:0] rd;
        logic        rv;
        idle(5);
        hold(4'b1000, seg_tab[1], 10);
        hold(4'b0100, seg_tab[7], 6);
        hold(4'b0100, seg_tab[8], 2);
        hold(4'b0100, seg_tab[7], 6);
        hold(4'b0010, seg_tab[0], 10);
        hold(4'b0001, seg_tab[0], 10);
        idle(12);
        do_read(1'b0, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'd1700}) begin
            errors++;
            $display("FAIL glitch_value got=%b/%h want=1/%h", rv, rd, 16'd1700);
        end
    endtask

    task automatic test_invalid;
        logic [15:0] rd;
        logic        rv;
        idle(5);
        scan_value(1234, 0, 10, 1'b0);
        idle(12);
        do_read(1'b0, rd, rv);
        hold(4'b0100, 7'h49, 10);
        idle(12);
        do_read(1'b1, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'h0002}) begin
            errors++;
            $display("FAIL invalid_status got=%b/%h want=1/0002", rv, rd);
        end
        do_read(1'b0, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'h04D2}) begin
            errors++;
            $display("FAIL invalid_keep_value got=%b/%h want=1/04d2", rv, rd);
        end
        do_read(1'b1, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL invalid_err_clr got=%b/%h want=1/0000", rv, rd);
        end
        scan_value(5678, 0, 10, 1'b0);
        idle(12);
        do_read(1'b0, rd, rv);
        checks++;
        if ({rv, rd} !== {1'b1, 16'h162E}) begin
            errors++;
            $display("FAIL s5678_value got=%b/%h want=1/162e", rv, rd);
        end
    endtask

    task automatic test_random;
        logic [15:0] rd;
        logic        rv;
        int          nlead;
        int          v;
        for (int i = 0; i < 10; i++) begin
            nlead = $urandom_range(0, 3);
            v = $urandom_range(0, pw[4 - nlead] - 1);
            idle($urandom_range(2, 6));
            scan_value(v, nlead, $urandom_range(6, 12), 1'b0);
            idle(12);
            do_read(1'b1, rd, rv);
            checks++;
            if ({rv, rd} !== {1'b1, 16'h0001}) begin
                errors++;
                $display("FAIL rand_status[%0d] got=%b/%h want=1/0001", i, rv, rd);
            end
            do_read(1'b0, rd, rv);
            checks++;
            if ({rv, rd} !== {1'b1, 16'(v)}) begin
                errors++;
                $display("FAIL rand_value[%0d] got=%b/%h want=1/%h", i, rv, rd, 16'(v));
            end
        end
    endtask

    task automatic test_publish_read;
        logic [15:0] rd;
        logic        rv;
        int          p;
        int          a;
        int          b;
        calibrate(p, a);
        if (p >= 5) begin
            b = $urandom_range(1000, 9999);
            if (b == a) b = (a == 9999) ? 1000 : a + 1;
            idle(10);
            scan_value(b, 0, 10, 1'b1);
            for (int c = 0; c <= p; c++) begin
                if (c < 10) begin
                    digits = 4'b0001;
                    segments = seg_tab[b % 10];
                end else begin
                    digits = 4'd0;
                    segments = 7'd0;
                end
                read = (c == p);
                address = 1'b0;
                cyc(1);
            end
            read = 1'b0;
            idle(1);
            checks++;
            if (readdata !== 16'(a)) begin
                errors++;
                $display("FAIL collide_old_value got=%h want=%h", readdata, 16'(a));
            end
            do_read(1'b1, rd, rv);
            checks++;
            if ({rv, rd} !== {1'b1, 16'h0001}) begin
                errors++;
                $display("FAIL collide_new_kept got=%b/%h want=1/0001", rv, rd);
            end
`ifdef SEG_CAPTURE_IRQ_EN
            checks++;
            if (irq !== 1'b1) begin
                errors++;
                $display("FAIL collide_irq got=%b want=1", irq);
            end
`endif
            do_read(1'b0, rd, rv);
            checks++;
            if ({rv, rd} !== {1'b1, 16'(b)}) begin
                errors++;
                $display("FAIL collide_new_value got=%b/%h want=1/%h", rv, rd, 16'(b));
            end
        end
    endtask

    task automatic test_reset_convert;
        logic [15:0] rd;
        logic        rv;
        int          p;
        int          a;
        int          v;
        calibrate(p, a);
        if (p >= 5) begin
            idle(10);
            scan_value(9999, 0, 10, 1'b1);
            for (int c = 0; c <= p - 3; c++) begin
                digits = (c < 10) ? 4'b0001 : 4'd0;
                segments = (c < 10) ? seg_tab[9] : 7'd0;
                cyc(1);
            end
            reset = 1'b0;
            #1;
            checks++;
            if ({readdatavalid, readdata} !== 17'd0) begin
                errors++;
                $display("FAIL midconv_reset_out got=%b/%h want=0/0000", readdatavalid, readdata);
            end
            cyc(1);
            reset = 1'b1;
            idle(15);
            do_read(1'b1, rd, rv);
            checks++;
            if ({rv, rd} !== {1'b1, 16'h0000}) begin
                errors++;
                $display("FAIL midconv_status got=%b/%h want=1/0000", rv, rd);
            end
            do_read(1'b0, rd, rv);
            checks++;
            if ({rv, rd} !== {1'b1, 16'h0000}) begin
                errors++;
                $display("FAIL midconv_value got=%b/%h want=1/0000", rv, rd);
            end
            v = $urandom_range(0, 9999);
            scan_value(v, 0, 10, 1'b0);
            idle(12);
            do_read(1'b0, rd, rv);
            checks++;
            if ({rv, rd} !== {1'b1, 16'(v)}) begin
                errors++;
                $display("FAIL after_reset_value got=%b/%h want=1/%h", rv, rd, 16'(v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_blank();
        test_glitch();
        test_invalid();
        test_random();
        test_publish_read();
        test_reset_convert();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
